// File: rtl/psx_controller_emu.sv
// psx_controller_emu: oversampled PlayStation pad emulator answering host polls with a
// configurable-length reply and counted active-low ack pulses.
module psx_controller_emu #(
  parameter int          N_DATA_BYTES = 2,
  parameter logic [7:0]  ID_BYTE      = 8'h41,
  parameter int          ACK_DELAY    = 4,
  parameter int          ACK_WIDTH    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      psx_clk_i,
  input  logic                      att_i,
  input  logic                      cmd_i,
  input  logic [8*N_DATA_BYTES-1:0] buttons_i,
  output logic                      data_o,
  output logic                      ack_o,
  output logic [7:0]                cmd_byte_o,
  output logic                      cmd_valid_o,
  output logic                      busy_o
);
  localparam int BW = $clog2(4 + N_DATA_BYTES);
  localparam int AM = (ACK_DELAY > ACK_WIDTH) ? ACK_DELAY : ACK_WIDTH;
  localparam int AW = $clog2(AM + 1);
  localparam int RW = 8 << BW;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {A_OFF, A_DELAY, A_PULSE} ack_t;
  logic [1:0]                psx_sync_q, att_sync_q, cmd_sync_q;
  logic                      psx_prev_q, att_prev_q;
  state_t                    state_q;
  ack_t                      ack_st_q;
  logic [AW-1:0]             ack_cnt_q;
  logic [BW-1:0]             byte_idx_q;
  logic [2:0]                bit_idx_q;
  logic [6:0]                rx_q;
  logic [8*N_DATA_BYTES-1:0] shadow_q;
  logic                      psx_rise, psx_fall, att_rise, att_fall;
  logic [7:0]                rx_byte;
  logic                      bad_cmd, last_byte;
  logic [RW-1:0]             reply_w;
  assign psx_rise  = psx_sync_q[1] & ~psx_prev_q;
  assign psx_fall  = ~psx_sync_q[1] & psx_prev_q;
  assign att_rise  = att_sync_q[1] & ~att_prev_q;
  assign att_fall  = ~att_sync_q[1] & att_prev_q;
  assign rx_byte   = {cmd_sync_q[1], rx_q};
  assign bad_cmd   = (byte_idx_q == BW'(0) && rx_byte != 8'h01) ||
                     (byte_idx_q == BW'(1) && rx_byte != 8'h42);
  assign last_byte = byte_idx_q == BW'(2 + N_DATA_BYTES);
  // Reply laid out LSB-first and padded to a power of two so {byte,bit} indexes it directly.
  assign reply_w   = {{(RW - 8*(N_DATA_BYTES + 3)){1'b1}}, shadow_q, 8'h5A, ID_BYTE, 8'hFF};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psx_sync_q <= 2'b11;
      att_sync_q <= 2'b11;
      cmd_sync_q <= 2'b11;
      psx_prev_q <= 1'b1;
      att_prev_q <= 1'b1;
    end else begin
      psx_sync_q <= {psx_sync_q[0], psx_clk_i};
      att_sync_q <= {att_sync_q[0], att_i};
      cmd_sync_q <= {cmd_sync_q[0], cmd_i};
      psx_prev_q <= psx_sync_q[1];
      att_prev_q <= att_sync_q[1];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ack_st_q    <= A_OFF;
      ack_cnt_q   <= '0;
      byte_idx_q  <= '0;
      bit_idx_q   <= '0;
      rx_q        <= '0;
      shadow_q    <= '0;
      data_o      <= 1'b1;
      ack_o       <= 1'b1;
      cmd_byte_o  <= '0;
      cmd_valid_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      cmd_valid_o <= 1'b0;
      if (att_rise) begin
        state_q  <= IDLE;
        ack_st_q <= A_OFF;
        data_o   <= 1'b1;
        ack_o    <= 1'b1;
        busy_o   <= 1'b0;
      end else begin
        if (ack_st_q == A_DELAY) begin
          if (ack_cnt_q == '0) begin
            ack_st_q  <= A_PULSE;
            ack_o     <= 1'b0;
            ack_cnt_q <= AW'(ACK_WIDTH - 1);
          end else ack_cnt_q <= ack_cnt_q - 1'b1;
        end else if (ack_st_q == A_PULSE) begin
          if (ack_cnt_q == '0) begin
            ack_st_q <= A_OFF;
            ack_o    <= 1'b1;
          end else ack_cnt_q <= ack_cnt_q - 1'b1;
        end
        unique case (state_q)
          IDLE: if (att_fall) begin
            shadow_q   <= buttons_i;
            byte_idx_q <= '0;
            bit_idx_q  <= '0;
            busy_o     <= 1'b1;
            state_q    <= SHIFT;
          end
          SHIFT: begin
            if (psx_fall) data_o <= reply_w[{byte_idx_q, bit_idx_q}];
            if (psx_rise) begin
              rx_q      <= rx_byte[7:1];
              bit_idx_q <= bit_idx_q + 3'd1;
              if (bit_idx_q == 3'd7) begin
                cmd_byte_o  <= rx_byte;
                cmd_valid_o <= 1'b1;
                byte_idx_q  <= byte_idx_q + BW'(1);
                if (bad_cmd || last_byte) begin
                  state_q <= DONE;
                  data_o  <= 1'b1;
                  busy_o  <= 1'b0;
                end else begin
                  ack_st_q  <= A_DELAY;
                  ack_cnt_q <= AW'(ACK_DELAY - 1);
                end
              end
            end
          end
          default: data_o <= 1'b1;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_psx_controller_emu.sv
// tb_psx_controller_emu: randomized host polls with a queue scoreboard; separate monitors
// check reply bytes at psx_clk rising edges and cmd_byte/ack timing at each cmd_valid.
module tb_psx_controller_emu;
  localparam int         N  = 2;
  localparam logic [7:0] ID = 8'h41;
  localparam int         D  = 4;
  localparam int         W  = 2;
  typedef struct {logic [7:0] b; int mode;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0, psx_clk = 1'b1, att = 1'b1, cmd = 1'b1;
  logic [8*N-1:0] buttons = '0;
  logic data, ack, cmd_valid, busy;
  logic [7:0] cmd_byte;
  int checks = 0, failures = 0;
  exp_t exp_cmd[$];
  logic [7:0] exp_data[$];
  logic [7:0] host_q[$];
  always #5 clk = ~clk;
  psx_controller_emu #(.N_DATA_BYTES(N), .ID_BYTE(ID), .ACK_DELAY(D), .ACK_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .psx_clk_i(psx_clk), .att_i(att), .cmd_i(cmd),
    .buttons_i(buttons), .data_o(data), .ack_o(ack), .cmd_byte_o(cmd_byte),
    .cmd_valid_o(cmd_valid), .busy_o(busy));
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic rand_buttons();
    for (int k = 0; k < N; k++) buttons[8*k +: 8] = 8'($urandom);
  endtask
  task automatic send_bits(input logic [7:0] c, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      psx_clk = 1'b0;
      cmd = c[i];
      cyc(8);
      psx_clk = 1'b1;
      if (i < nbits - 1) cyc(8);
    end
  endtask
  // Reference: reply is FF, ID, 5A, latched payload; poll aborts after a bad header or the last byte.
  task automatic run_txn(input bit att_in_pulse);
    logic [7:0] rep[$];
    logic [8*N-1:0] latched;
    bit alive, term;
    int m, t;
    att = 1'b0;
    cyc(6);
    latched = buttons;
    rand_buttons();
    cyc(4);
    rep = '{8'hFF, ID, 8'h5A};
    for (int k = 0; k < N; k++) rep.push_back(latched[8*k +: 8]);
    alive = 1'b1;
    foreach (host_q[i]) begin
      exp_data.push_back((alive && i < rep.size()) ? rep[i] : 8'hFF);
      if (alive) begin
        term = (i == 0 && host_q[i] != 8'h01) || (i == 1 && host_q[i] != 8'h42) || (i == N + 2);
        m = term ? 0 : ((att_in_pulse && i == host_q.size() - 1) ? 2 : 1);
        exp_cmd.push_back('{host_q[i], m});
        alive = !term;
      end
    end
    foreach (host_q[i]) begin
      send_bits(host_q[i], 8);
      if (!(att_in_pulse && i == host_q.size() - 1)) cyc(16);
    end
    if (att_in_pulse) begin
      t = 0;
      while (ack !== 1'b0 && t < 30) begin
        cyc(1);
        t++;
      end
      check("ack_low_before_att", ack, 0);
      att = 1'b1;
      cyc(3);
      check("ack_release_on_att", ack, 1);
      cyc(6);
    end else begin
      check("busy_end", busy, alive);
      att = 1'b1;
      cyc(6);
    end
    check("busy_idle", busy, 0);
    check("data_idle", data, 1);
    check("ack_idle", ack, 1);
    cyc(10);
  endtask
  logic [7:0] bits;
  int nb = 0;
  logic att_d = 1'b1;
  always @(posedge psx_clk or att) begin
    if (att) att_d = 1'b1;
    else if (att_d) begin
      att_d = 1'b0;
      nb = 0;
    end else if (psx_clk) begin
      bits[nb] = data;
      nb++;
      if (nb == 8) begin
        nb = 0;
        if (exp_data.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL data_unexpected: got %0h expected none", bits);
        end else check("data_byte", bits, exp_data.pop_front());
      end
    end
  end
  initial begin
    int since = 1000;
    int mode = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (cmd_valid) begin
        if (exp_cmd.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL cmd_valid_unexpected: got cmd_byte %0h expected no pulse", cmd_byte);
          mode = 0;
        end else begin
          e = exp_cmd.pop_front();
          check("cmd_byte", cmd_byte, e.b);
          mode = e.mode;
        end
        since = 0;
      end else if (since < 1000) since++;
      if (mode != 2 && (ack === 1'b0 || (mode == 1 && since <= D + W)))
        check("ack_level", ack, (mode == 1 && since >= D && since < D + W) ? 0 : 1);
    end
  end
  initial begin
    cyc(3);
    check("rst_data", data, 1);
    check("rst_ack", ack, 1);
    check("rst_cmd_byte", cmd_byte, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    cyc(5);
    buttons = 16'hFF7F;
    host_q = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00};
    run_txn(1'b0);
    host_q = '{8'h81, 8'h42, 8'h00, 8'h00};
    run_txn(1'b0);
    host_q = '{8'h01, 8'h43, 8'h00};
    run_txn(1'b0);
    rand_buttons();
    host_q = '{8'h01, 8'h42, 8'hAA, 8'h55, 8'h33, 8'h77};
    run_txn(1'b0);
    host_q = '{8'h01, 8'h42};
    run_txn(1'b1);
    rand_buttons();
    att = 1'b0;
    cyc(10);
    exp_data.push_back(8'hFF);
    exp_data.push_back(ID);
    exp_cmd.push_back('{8'h01, 1});
    exp_cmd.push_back('{8'h42, 1});
    send_bits(8'h01, 8);
    cyc(16);
    send_bits(8'h42, 8);
    cyc(16);
    send_bits(8'h00, 5);
    cyc(8);
    psx_clk = 1'b0;
    cyc(5);
    check("pre_rst_busy", busy, 1);
    check("pre_rst_data", data, 0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_data", data, 1);
    check("mid_rst_ack", ack, 1);
    check("mid_rst_busy", busy, 0);
    att = 1'b1;
    psx_clk = 1'b1;
    cmd = 1'b1;
    cyc(5);
    rst_n = 1'b1;
    cyc(5);
    host_q = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00};
    run_txn(1'b0);
    for (int r = 0; r < 15; r++) begin
      int n;
      rand_buttons();
      n = $urandom_range(1, N + 5);
      host_q.delete();
      for (int i = 0; i < n; i++) begin
        logic [7:0] c;
        c = 8'($urandom);
        if (i == 0 && $urandom_range(0, 4) != 0) c = 8'h01;
        if (i == 1 && $urandom_range(0, 4) != 0) c = 8'h42;
        host_q.push_back(c);
      end
      run_txn(1'b0);
    end
    cyc(20);
    check("data_queue_drained", exp_data.size(), 0);
    check("cmd_queue_drained", exp_cmd.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
